data_path: RTL and testbench



---
 rtl/data_path.sv | 181 ++++++++++++++++++
 tb/tb_data_path.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_path.sv
// Mini SRC single-bus datapath: register file slice, shared bus multiplexer,
// Y/Z latches around a combinational ALU, plus HI/LO and memory interface registers.
module data_path #(
  parameter int WIDTH = 32
) (
  input  logic             w_clock,
  input  logic             w_clear,
  input  logic             w_IncPC,
  input  logic             e_R1,
  input  logic             e_R2,
  input  logic             e_R3,
  input  logic             e_R4,
  input  logic             e_R5,
  input  logic             e_MAR,
  input  logic             e_PC,
  input  logic             e_IR,
  input  logic             e_Y,
  input  logic             e_HI,
  input  logic             e_LO,
  input  logic             e_MDR,
  input  logic             e_Z,
  input  logic             s_PC,
  input  logic             s_Zlow,
  input  logic             s_MDR,
  input  logic             s_R2,
  input  logic             s_R3,
  input  logic             s_R4,
  input  logic             s_R5,
  input  logic             w_read,
  input  logic [5:0]       opcode,
  input  logic             e_alu,
  input  logic [WIDTH-1:0] w_Mdatain,
  output logic [WIDTH-1:0] o_bus,
  output logic [WIDTH-1:0] o_R1,
  output logic [WIDTH-1:0] o_IR,
  output logic [WIDTH-1:0] o_MAR,
  output logic [WIDTH-1:0] o_Zhigh,
  output logic [WIDTH-1:0] o_Zlow,
  output logic [WIDTH-1:0] o_HI,
  output logic [WIDTH-1:0] o_LO
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_AND  = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b000011;
  localparam logic [5:0] OP_NOT  = 6'b000100;
  localparam logic [5:0] OP_MUL  = 6'b000101;
  localparam logic [5:0] OP_DIV  = 6'b000110;
  localparam logic [5:0] OP_ROL  = 6'b000111;
  localparam logic [5:0] OP_ROR  = 6'b001000;
  localparam logic [5:0] OP_SHR  = 6'b001001;
  localparam logic [5:0] OP_SHRA = 6'b001010;
  localparam logic [5:0] OP_SHL  = 6'b001011;
  localparam logic [5:0] OP_NEG  = 6'b001100;

  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0]   r1_q, r2_q, r3_q, r4_q, r5_q;
  logic [WIDTH-1:0]   r1_d, r2_d, r3_d, r4_d, r5_d;
  logic [WIDTH-1:0]   pc_q, ir_q, mar_q, mdr_q, y_q, hi_q, lo_q;
  logic [WIDTH-1:0]   pc_d, ir_d, mar_d, mdr_d, y_d, hi_d, lo_d;
  logic [2*WIDTH-1:0] z_q, z_d;

  logic [WIDTH-1:0]   bus;
  logic [2*WIDTH-1:0] alu_z;
  logic [WIDTH-1:0]   alu_a, alu_b;
  logic [2*WIDTH-1:0] a_sx, b_sx;
  logic [SW-1:0]      sh;

  // Fixed-priority bus source selection; an idle bus reads as zero.
  always_comb begin
    bus = '0;
    if (s_MDR)       bus = mdr_q;
    else if (s_Zlow) bus = z_q[WIDTH-1:0];
    else if (s_PC)   bus = pc_q;
    else if (s_R2)   bus = r2_q;
    else if (s_R3)   bus = r3_q;
    else if (s_R4)   bus = r4_q;
    else if (s_R5)   bus = r5_q;
  end

  assign alu_a = y_q;
  assign alu_b = bus;
  assign a_sx  = {{WIDTH{alu_a[WIDTH-1]}}, alu_a};
  assign b_sx  = {{WIDTH{alu_b[WIDTH-1]}}, alu_b};
  assign sh    = alu_b[SW-1:0];

  // Rotates use (0 - sh) as the complementary shift so sh = 0 returns A unchanged.
  always_comb begin
    alu_z = '0;
    case (opcode)
      OP_ADD:  alu_z[WIDTH-1:0] = alu_a + alu_b;
      OP_SUB:  alu_z[WIDTH-1:0] = alu_a - alu_b;
      OP_AND:  alu_z[WIDTH-1:0] = alu_a & alu_b;
      OP_OR:   alu_z[WIDTH-1:0] = alu_a | alu_b;
      OP_NOT:  alu_z[WIDTH-1:0] = ~alu_b;
      OP_MUL:  alu_z = a_sx * b_sx;
      OP_DIV: begin
        if (alu_b == '0) begin
          alu_z = '0;
        end else if (alu_a == INT_MIN && alu_b == '1) begin
          alu_z[WIDTH-1:0] = INT_MIN;
        end else begin
          alu_z[WIDTH-1:0]       = $signed(alu_a) / $signed(alu_b);
          alu_z[2*WIDTH-1:WIDTH] = $signed(alu_a) % $signed(alu_b);
        end
      end
      OP_ROL:  alu_z[WIDTH-1:0] = (alu_a << sh) | (alu_a >> (SW'(0) - sh));
      OP_ROR:  alu_z[WIDTH-1:0] = (alu_a >> sh) | (alu_a << (SW'(0) - sh));
      OP_SHR:  alu_z[WIDTH-1:0] = alu_a >> sh;
      OP_SHRA: alu_z[WIDTH-1:0] = WIDTH'($signed(alu_a) >>> sh);
      OP_SHL:  alu_z[WIDTH-1:0] = alu_a << sh;
      OP_NEG:  alu_z[WIDTH-1:0] = WIDTH'(0) - alu_b;
      default: alu_z = '0;
    endcase
  end

  always_comb begin
    r1_d  = e_R1  ? bus : r1_q;
    r2_d  = e_R2  ? bus : r2_q;
    r3_d  = e_R3  ? bus : r3_q;
    r4_d  = e_R4  ? bus : r4_q;
    r5_d  = e_R5  ? bus : r5_q;
    pc_d  = e_PC  ? bus : pc_q;
    ir_d  = e_IR  ? bus : ir_q;
    mar_d = e_MAR ? bus : mar_q;
    y_d   = e_Y   ? bus : y_q;
    hi_d  = e_HI  ? bus : hi_q;
    lo_d  = e_LO  ? bus : lo_q;
    mdr_d = mdr_q;
    if (e_MDR) mdr_d = w_read ? w_Mdatain : bus;
    z_d = z_q;
    if (e_Z && w_IncPC)    z_d = {{WIDTH{1'b0}}, bus + WIDTH'(1)};
    else if (e_Z && e_alu) z_d = alu_z;
  end

  always_ff @(posedge w_clock) begin
    if (w_clear) begin
      r1_q  <= '0;
      r2_q  <= '0;
      r3_q  <= '0;
      r4_q  <= '0;
      r5_q  <= '0;
      pc_q  <= '0;
      ir_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      y_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      z_q   <= '0;
    end else begin
      r1_q  <= r1_d;
      r2_q  <= r2_d;
      r3_q  <= r3_d;
      r4_q  <= r4_d;
      r5_q  <= r5_d;
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      y_q   <= y_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      z_q   <= z_d;
    end
  end

  assign o_bus   = bus;
  assign o_R1    = r1_q;
  assign o_IR    = ir_q;
  assign o_MAR   = mar_q;
  assign o_Zhigh = z_q[2*WIDTH-1:WIDTH];
  assign o_Zlow  = z_q[WIDTH-1:0];
  assign o_HI    = hi_q;
  assign o_LO    = lo_q;

endmodule

// File: tb/tb_data_path.sv
// Directed self-checking bench for data_path: register transfers, fetch,
// ALU operations with hand-computed results, and a mid-sequence reset.
module tb_data_path;

  logic        w_clock, w_clear, w_IncPC;
  logic        e_R1, e_R2, e_R3, e_R4, e_R5;
  logic        e_MAR, e_PC, e_IR, e_Y, e_HI, e_LO, e_MDR, e_Z;
  logic        s_PC, s_Zlow, s_MDR, s_R2, s_R3, s_R4, s_R5;
  logic        w_read, e_alu;
  logic [5:0]  opcode;
  logic [31:0] w_Mdatain;
  logic [31:0] o_bus, o_R1, o_IR, o_MAR, o_Zhigh, o_Zlow, o_HI, o_LO;

  int nChecks = 0;
  int nFail   = 0;

  data_path #(.WIDTH(32)) dut (
    .w_clock(w_clock), .w_clear(w_clear), .w_IncPC(w_IncPC),
    .e_R1(e_R1), .e_R2(e_R2), .e_R3(e_R3), .e_R4(e_R4), .e_R5(e_R5),
    .e_MAR(e_MAR), .e_PC(e_PC), .e_IR(e_IR), .e_Y(e_Y), .e_HI(e_HI),
    .e_LO(e_LO), .e_MDR(e_MDR), .e_Z(e_Z),
    .s_PC(s_PC), .s_Zlow(s_Zlow), .s_MDR(s_MDR), .s_R2(s_R2), .s_R3(s_R3),
    .s_R4(s_R4), .s_R5(s_R5), .w_read(w_read), .opcode(opcode), .e_alu(e_alu),
    .w_Mdatain(w_Mdatain), .o_bus(o_bus), .o_R1(o_R1), .o_IR(o_IR),
    .o_MAR(o_MAR), .o_Zhigh(o_Zhigh), .o_Zlow(o_Zlow), .o_HI(o_HI), .o_LO(o_LO)
  );

  initial begin
    w_clock = 1'b0;
    forever #5 w_clock = ~w_clock;
  end

  task automatic clearCtrl();
    w_clear = 0; w_IncPC = 0; w_read = 0; e_alu = 0; opcode = 6'd0;
    e_R1 = 0; e_R2 = 0; e_R3 = 0; e_R4 = 0; e_R5 = 0;
    e_MAR = 0; e_PC = 0; e_IR = 0; e_Y = 0; e_HI = 0; e_LO = 0; e_MDR = 0; e_Z = 0;
    s_PC = 0; s_Zlow = 0; s_MDR = 0; s_R2 = 0; s_R3 = 0; s_R4 = 0; s_R5 = 0;
  endtask

  // One clock step: the controls set beforehand act on this edge, then are dropped.
  task automatic applyStimulus();
    @(posedge w_clock);
    #1;
    clearCtrl();
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFail++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("[TB] check %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic mdrLoad(input logic [31:0] value);
    w_read = 1; e_MDR = 1; w_Mdatain = value;
    applyStimulus();
  endtask

  // Y <- a, then bus <- b through MDR while the ALU result is captured in Z.
  task automatic aluOp(input logic [31:0] a, input logic [31:0] b, input logic [5:0] op);
    mdrLoad(a);
    s_MDR = 1; e_Y = 1;
    applyStimulus();
    mdrLoad(b);
    s_MDR = 1; opcode = op; e_Z = 1; e_alu = 1;
    applyStimulus();
  endtask

  initial begin
    clearCtrl();
    w_Mdatain = 32'h0;

    w_clear = 1;
    applyStimulus();
    checkOutput("reset_R1", o_R1, 32'h0);
    checkOutput("reset_IR", o_IR, 32'h0);
    checkOutput("reset_MAR", o_MAR, 32'h0);
    checkOutput("reset_Zhigh", o_Zhigh, 32'h0);
    checkOutput("reset_Zlow", o_Zlow, 32'h0);
    checkOutput("reset_HI", o_HI, 32'h0);
    checkOutput("reset_LO", o_LO, 32'h0);
    checkOutput("idle_bus", o_bus, 32'h0);

    mdrLoad(32'h12);
    s_MDR = 1; e_R2 = 1; #1;
    checkOutput("bus_mdr_to_r2", o_bus, 32'h12);
    applyStimulus();
    mdrLoad(32'h2);
    s_MDR = 1; e_R3 = 1;
    applyStimulus();
    mdrLoad(32'h18);
    s_MDR = 1; e_R1 = 1;
    applyStimulus();
    checkOutput("load_R1", o_R1, 32'h18);
    s_R2 = 1; #1;
    checkOutput("bus_R2", o_bus, 32'h12);
    s_R3 = 1; #1;
    checkOutput("prio_R2_over_R3", o_bus, 32'h12);
    s_R2 = 0; #1;
    checkOutput("bus_R3", o_bus, 32'h2);
    s_MDR = 1; #1;
    checkOutput("prio_MDR_over_R3", o_bus, 32'h18);
    clearCtrl();

    s_PC = 1; e_MAR = 1; w_IncPC = 1; e_Z = 1; #1;
    checkOutput("T0_bus_pc", o_bus, 32'h0);
    applyStimulus();
    checkOutput("T0_MAR", o_MAR, 32'h0);
    checkOutput("T0_Zlow", o_Zlow, 32'h1);
    s_Zlow = 1; e_PC = 1; w_read = 1; e_MDR = 1; w_Mdatain = 32'h28918000;
    applyStimulus();
    s_PC = 1; #1;
    checkOutput("T1_PC", o_bus, 32'h1);
    s_PC = 0; s_MDR = 1; e_IR = 1;
    applyStimulus();
    checkOutput("T2_IR", o_IR, 32'h28918000);

    s_R2 = 1; e_Y = 1;
    applyStimulus();
    s_R3 = 1; opcode = 6'b001000; e_Z = 1; e_alu = 1;
    applyStimulus();
    checkOutput("ror_Zlow", o_Zlow, 32'h80000004);
    checkOutput("ror_Zhigh", o_Zhigh, 32'h0);
    s_Zlow = 1; e_R1 = 1; e_LO = 1;
    applyStimulus();
    checkOutput("T5_R1", o_R1, 32'h80000004);
    checkOutput("T5_LO", o_LO, 32'h80000004);

    s_R3 = 1; e_HI = 1; e_MAR = 1;
    applyStimulus();
    checkOutput("load_HI", o_HI, 32'h2);
    checkOutput("load_MAR", o_MAR, 32'h2);

    aluOp(32'd7, 32'd2, 6'b000000);
    checkOutput("add", o_Zlow, 32'd9);
    aluOp(32'd2, 32'd7, 6'b000001);
    checkOutput("sub", o_Zlow, 32'hFFFFFFFB);
    aluOp(32'hF0F0_1234, 32'h0FF0_FF00, 6'b000010);
    checkOutput("and", o_Zlow, 32'h00F0_1200);
    aluOp(32'hF0F0_1234, 32'h0FF0_FF00, 6'b000011);
    checkOutput("or", o_Zlow, 32'hFFF0_FF34);
    aluOp(32'h0, 32'h0000_FFFF, 6'b000100);
    checkOutput("not", o_Zlow, 32'hFFFF_0000);

    aluOp(32'hFFFFFFFB, 32'd3, 6'b000101);
    checkOutput("mul_Zhigh", o_Zhigh, 32'hFFFFFFFF);
    checkOutput("mul_Zlow", o_Zlow, 32'hFFFFFFF1);
    aluOp(32'd7, 32'd2, 6'b000110);
    checkOutput("div_Zlow", o_Zlow, 32'd3);
    checkOutput("div_Zhigh", o_Zhigh, 32'd1);
    aluOp(32'hFFFFFFF9, 32'd2, 6'b000110);
    checkOutput("divneg_Zlow", o_Zlow, 32'hFFFFFFFD);
    checkOutput("divneg_Zhigh", o_Zhigh, 32'hFFFFFFFF);
    aluOp(32'd7, 32'd0, 6'b000110);
    checkOutput("div0_Zlow", o_Zlow, 32'h0);
    checkOutput("div0_Zhigh", o_Zhigh, 32'h0);

    aluOp(32'h80000000, 32'd4, 6'b001010);
    checkOutput("shra", o_Zlow, 32'hF8000000);
    aluOp(32'h80000000, 32'd4, 6'b001001);
    checkOutput("shr", o_Zlow, 32'h08000000);
    aluOp(32'h80000001, 32'd4, 6'b001011);
    checkOutput("shl", o_Zlow, 32'h00000010);
    aluOp(32'h80000000, 32'd4, 6'b000111);
    checkOutput("rol", o_Zlow, 32'h00000008);
    aluOp(32'h12345678, 32'd0, 6'b000111);
    checkOutput("rol_by_0", o_Zlow, 32'h12345678);
    aluOp(32'h0, 32'd1, 6'b001100);
    checkOutput("neg", o_Zlow, 32'hFFFFFFFF);
    aluOp(32'd5, 32'd1, 6'b001101);
    checkOutput("bad_opcode", o_Zlow, 32'h0);

    mdrLoad(32'd9);
    s_MDR = 1; opcode = 6'b000000; e_alu = 1;
    applyStimulus();
    checkOutput("Z_hold_no_eZ", o_Zlow, 32'h0);

    mdrLoad(32'hFFFFFFFF);
    s_MDR = 1; w_IncPC = 1; e_Z = 1;
    applyStimulus();
    checkOutput("incpc_wrap", o_Zlow, 32'h0);
    mdrLoad(32'h41);
    s_MDR = 1; w_IncPC = 1; e_alu = 1; opcode = 6'b001100; e_Z = 1;
    applyStimulus();
    checkOutput("incpc_over_alu", o_Zlow, 32'h42);

    s_R2 = 1; e_Y = 1;
    applyStimulus();
    s_R3 = 1; opcode = 6'b000000; e_Z = 1; e_alu = 1; w_clear = 1;
    applyStimulus();
    checkOutput("clr_R1", o_R1, 32'h0);
    checkOutput("clr_IR", o_IR, 32'h0);
    checkOutput("clr_MAR", o_MAR, 32'h0);
    checkOutput("clr_Zlow", o_Zlow, 32'h0);
    checkOutput("clr_HI", o_HI, 32'h0);
    checkOutput("clr_LO", o_LO, 32'h0);
    s_R2 = 1; #1;
    checkOutput("clr_bus_R2", o_bus, 32'h0);
    s_R2 = 0; s_PC = 1; #1;
    checkOutput("clr_bus_PC", o_bus, 32'h0);
    s_PC = 0; s_MDR = 1; #1;
    checkOutput("clr_bus_MDR", o_bus, 32'h0);
    clearCtrl();

    mdrLoad(32'h12);
    s_MDR = 1; e_R2 = 1;
    applyStimulus();
    s_R2 = 1; #1;
    checkOutput("resume_R2", o_bus, 32'h12);
    clearCtrl();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
